// File: rtl/hangman_pkg.sv
// Shared constants and scancode lookup for the hangman keyboard and text paths.
// Latency: n/a (package only).
// Backpressure: n/a.
package hangman_pkg;

  localparam logic [4:0] LETTER_ENTER = 5'd26;
  localparam logic [4:0] LETTER_NONE  = 5'd31;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  // Set-2 make code to letter index (A=0 .. Z=25, Enter=26); anything else maps to NONE.
  function automatic logic [4:0] scancode_to_letter(input logic [7:0] sc);
    logic [4:0] code;
    code = LETTER_NONE;
    case (sc)
      8'h1C: code = 5'd0;   8'h32: code = 5'd1;   8'h21: code = 5'd2;
      8'h23: code = 5'd3;   8'h24: code = 5'd4;   8'h2B: code = 5'd5;
      8'h34: code = 5'd6;   8'h33: code = 5'd7;   8'h43: code = 5'd8;
      8'h3B: code = 5'd9;   8'h42: code = 5'd10;  8'h4B: code = 5'd11;
      8'h3A: code = 5'd12;  8'h31: code = 5'd13;  8'h44: code = 5'd14;
      8'h4D: code = 5'd15;  8'h15: code = 5'd16;  8'h2D: code = 5'd17;
      8'h1B: code = 5'd18;  8'h2C: code = 5'd19;  8'h3C: code = 5'd20;
      8'h2A: code = 5'd21;  8'h1D: code = 5'd22;  8'h22: code = 5'd23;
      8'h35: code = 5'd24;  8'h1A: code = 5'd25;  8'h5A: code = LETTER_ENTER;
      default: code = LETTER_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 pin synchroniser, falling-edge detect, 11-bit frame FSM with idle timeout.
// Latency: byte_valid/byte_err are combinational strobes in the cycle the stop-bit edge is seen.
// Backpressure: none; the keyboard cannot be stalled, so every byte is presented exactly once.
module ps2_rx_frame
  import hangman_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic clk_s1, clk_s2, clk_d;
  logic dat_s1, dat_s2;

  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [CW-1:0] to_cnt;

  logic fall;
  logic stop_ok;
  logic timeout_hit;

  // Two-flop synchronisers plus the edge register; idle-high reset so reset release is not an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  assign fall        = clk_d & ~clk_s2;
  assign stop_ok     = dat_s2 & (^{shreg, par_bit});
  assign timeout_hit = !fall && (state != FR_IDLE) && (to_cnt == TO_LAST);

  // Frame FSM: sample data on each falling edge, abandon a partial frame after the idle timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= FR_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else if (fall) begin
      to_cnt <= '0;
      case (state)
        FR_IDLE: begin
          if (!dat_s2) begin
            state   <= FR_DATA;
            bit_cnt <= 3'd0;
          end
        end
        FR_DATA: begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= FR_PARITY;
        end
        FR_PARITY: begin
          par_bit <= dat_s2;
          state   <= FR_STOP;
        end
        default: state <= FR_IDLE;
      endcase
    end else if (state != FR_IDLE) begin
      if (timeout_hit) begin
        state  <= FR_IDLE;
        to_cnt <= '0;
      end else if (to_cnt != CNT_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end else begin
      to_cnt <= '0;
    end
  end

  assign byte_valid = fall && (state == FR_STOP) && stop_ok;
  assign byte_err   = (fall && (state == FR_STOP) && !stop_ok) || timeout_hit;
  assign byte_data  = shreg;

endmodule

// File: rtl/ps2_letter_rx.sv
// PS/2 keyboard to letter strobe: decodes make/break/extended codes and drops repeats.
// Latency: pressed/frame_err rise 1 clk after the stop-bit edge (edge is 3 clk after the pin falls).
// Backpressure: none; pressed is a one-cycle strobe and letter holds until the next press.
module ps2_letter_rx
  import hangman_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       pressed,
  output logic [4:0] letter,
  output logic       held,
  output logic       frame_err
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;

  logic       brk;
  logic       ext;
  logic [7:0] last_code;
  logic [4:0] code_map;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_err  (byte_err)
  );

  // Extended codes only recognise keypad Enter; plain codes go through the shared table.
  always_comb begin
    code_map = LETTER_NONE;
    if (ext) begin
      if (byte_data == SC_ENTER) code_map = LETTER_ENTER;
    end else begin
      code_map = scancode_to_letter(byte_data);
    end
  end

  // Prefix tracking, release/repeat suppression and registered press/error strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pressed   <= 1'b0;
      letter    <= LETTER_NONE;
      held      <= 1'b0;
      frame_err <= 1'b0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      last_code <= 8'd0;
    end else begin
      pressed   <= 1'b0;
      frame_err <= 1'b0;
      if (byte_err) begin
        // A damaged frame may have been a prefix; forget prefixes so the next code reads clean.
        frame_err <= 1'b1;
        brk       <= 1'b0;
        ext       <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == SC_BREAK) begin
          brk <= 1'b1;
        end else if (byte_data == SC_EXT) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (brk) begin
            if (byte_data == last_code) begin
              held      <= 1'b0;
              last_code <= 8'd0;
            end
          end else if (code_map != LETTER_NONE &&
                       !(held && byte_data == last_code)) begin
            letter    <= code_map;
            pressed   <= 1'b1;
            held      <= 1'b1;
            last_code <= byte_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_letter_rx.sv
module tb_ps2_letter_rx;

  localparam int TO   = 50000;
  localparam int HALF = 200;   // ns, half a PS/2 clock period (10 system clocks)

  logic       clk;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       pressed;
  logic [4:0] letter;
  logic       held;
  logic       frame_err;

  ps2_letter_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .pressed  (pressed),
    .letter   (letter),
    .held     (held),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [4:0] letter;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state: prefixes, the key believed held, and the Set-2 letter table.
  bit         m_brk, m_ext, m_held;
  logic [7:0] m_last;
  logic [7:0] last_made;
  logic [7:0] sc_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                              8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                              8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                              8'h35, 8'h1A};

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [7:0] b, input bit extended);
    int idx;
    idx = -1;
    if (b == 8'h5A) idx = 26;
    else if (!extended)
      for (int i = 0; i < 26; i++) if (sc_tab[i] == b) idx = i;
    return idx;
  endfunction

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_held = 0; m_last = 8'd0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int   idx;
    exp_t e;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      idx = lookup(b, m_ext);
      if (m_brk) begin
        if (b == m_last) begin
          m_held = 0;
          m_last = 8'd0;
        end
      end else if (idx >= 0 && !(m_held && b == m_last)) begin
        e.is_err = 0;
        e.letter = 5'(idx);
        q.push_back(e);
        m_held = 1;
        m_last = b;
        last_made = b;
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    #(HALF);
    ps2_clk = 1'b0;
    #(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    #(HALF * 4);
  endtask

  task automatic key(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 0);
    check("held", held, m_held);
  endtask

  task automatic bad_key(input logic [7:0] b);
    exp_t e;
    e.is_err = 1;
    e.letter = 5'd0;
    q.push_back(e);
    m_brk = 0;
    m_ext = 0;
    send_frame(b, 1);
  endtask

  // Monitor: pop the scoreboard whenever the DUT strobes, and police the strobe rules.
  bit prev_pressed = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (pressed || frame_err)
          check("pressed_and_err", int'(pressed && frame_err), 0);
        if (pressed)
          check("pressed_back_to_back", int'(prev_pressed), 0);
        if (pressed) begin
          if (q.size() == 0) check("unexpected_press", 1, 0);
          else begin
            e = q.pop_front();
            check("press_kind", int'(e.is_err), 0);
            check("letter", letter, e.letter);
            check("held_at_press", held, 1);
          end
        end else if (frame_err) begin
          if (q.size() == 0) check("unexpected_err", 1, 0);
          else begin
            e = q.pop_front();
            check("err_kind", int'(e.is_err), 1);
          end
        end
      end
      prev_pressed = pressed;
    end
  end

  initial begin
    exp_t e;
    int   r;
    logic [7:0] b;
    ps2_clk   = 1'b1;
    ps2_dat   = 1'b1;
    resetn    = 1'b0;
    last_made = 8'h1C;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("rst_pressed", pressed, 0);
    check("rst_letter", letter, 31);
    check("rst_held", held, 0);
    check("rst_frame_err", frame_err, 0);
    resetn = 1'b1;
    repeat (5) @(posedge clk);

    // Press and release A.
    key(8'h1C); key(8'hF0); key(8'h1C);
    // Typematic Enter then release.
    key(8'h5A); key(8'h5A); key(8'h5A); key(8'hF0); key(8'h5A);
    // Keypad Enter, ignored arrow, then B.
    key(8'hE0); key(8'h5A); key(8'hE0); key(8'h75); key(8'h32);
    // Parity error, then R.
    bad_key(8'h2D); key(8'h2D);

    // Partial frame abandoned by timeout, then Z.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    e.is_err = 1;
    e.letter = 5'd0;
    q.push_back(e);
    m_brk = 0;
    m_ext = 0;
    repeat (TO + 100) @(posedge clk);
    check("timeout_consumed", q.size(), 0);
    key(8'h1A);

    // Reset in the middle of a frame's data bits.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    resetn = 1'b0;
    #1;
    check("midrst_pressed", pressed, 0);
    check("midrst_letter", letter, 31);
    check("midrst_held", held, 0);
    check("midrst_frame_err", frame_err, 0);
    model_reset();
    q.delete();
    repeat (5) @(posedge clk);
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    key(8'h15);

    // Randomised keyboard traffic.
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: key(sc_tab[$urandom_range(0, 25)]);
        3: key(8'h5A);
        4: key(last_made);
        5: begin key(8'hF0); key(last_made); end
        6: begin
          key(8'hE0);
          case ($urandom_range(0, 2))
            0: key(8'h5A);
            1: key(8'h75);
            default: key(8'($urandom_range(0, 255)));
          endcase
        end
        7: key(8'($urandom_range(0, 255)));
        8: bad_key(8'($urandom_range(0, 255)));
        default: begin key(8'hF0); key(sc_tab[$urandom_range(0, 25)]); end
      endcase
    end

    repeat (50) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
